// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) transmit/receive path.
//   CW_WIDTH    : codeword width (bits per serial frame)
//   DATA_WIDTH  : payload bits per codeword
//   ser_state_e : serializer control state
package hamming_pkg;

  localparam int CW_WIDTH   = 7;
  localparam int DATA_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/bing_to_chuan7.sv
// Parallel-to-serial converter for Hamming(7,4) codewords.
// Accepts one codeword per valid/ready transfer into a one-word holding
// buffer and shifts it out one bit per clk16 cycle. When the holding buffer
// is already full as the last bit of a frame goes out, the next frame follows
// with no idle cycle in between.
//
// Ports:
//   clk16       in  bit clock, all state on the rising edge
//   rst_n       in  asynchronous reset, active low
//   cw_in       in  parallel codeword from the encoder
//   cw_valid    in  cw_in is valid
//   cw_ready    out holding buffer can accept (transfer = cw_valid & cw_ready)
//   ser_out     out serial bit (registered)
//   ser_valid   out ser_out carries a codeword bit this cycle
//   frame_start out high together with the first bit of every frame
//   busy        out shifter or holding buffer occupied
module bing_to_chuan7 #(
  parameter int   CW_WIDTH   = hamming_pkg::CW_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                clk16,
  input  logic                rst_n,
  input  logic [CW_WIDTH-1:0] cw_in,
  input  logic                cw_valid,
  output logic                cw_ready,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                frame_start,
  output logic                busy
);

  import hamming_pkg::*;

  localparam int                CNT_W    = $clog2(CW_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CW_WIDTH - 1);

  ser_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CW_WIDTH-1:0] shift_q, shift_d;
  logic [CW_WIDTH-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                ser_out_q, ser_out_d;
  logic                ser_valid_q, ser_valid_d;
  logic                frame_start_q, frame_start_d;

  logic last_bit;
  logic load;
  logic xfer;

  // The last bit of the current frame is on ser_out during this cycle.
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign load     = hold_full_q && ((state_q == IDLE) || last_bit);
  // Ready depends on registered state only, never on cw_valid.
  assign cw_ready = !hold_full_q || load;
  assign xfer     = cw_valid && cw_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    ser_out_d     = IDLE_LEVEL;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;

    // Holding buffer: a load empties it, a transfer on the same edge refills it.
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (xfer) begin
      hold_d      = cw_in;
      hold_full_d = 1'b1;
    end

    if (load) begin
      state_d       = SHIFT;
      cnt_d         = '0;
      shift_d       = hold_q;
      ser_out_d     = MSB_FIRST ? hold_q[CW_WIDTH-1] : hold_q[0];
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
    end else if ((state_q == SHIFT) && !last_bit) begin
      // The bit currently on ser_out sits at the leading end of shift_q;
      // present its neighbour and move the register one place along.
      cnt_d       = cnt_q + CNT_W'(1);
      ser_out_d   = MSB_FIRST ? shift_q[CW_WIDTH-2] : shift_q[1];
      shift_d     = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
      ser_valid_d = 1'b1;
    end else begin
      // Idle, or underrun after the last bit: line returns to its idle level.
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      // NOTE: the data registers are cleared as well; they are tiny, and a
      // known value keeps X out of the shifter after a mid-frame reset.
      shift_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      ser_out_q     <= IDLE_LEVEL;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = hold_full_q || (state_q == SHIFT);

endmodule

// File: tb/tb_bing_to_chuan7.sv
// Self-checking bench for bing_to_chuan7.
// A monitor records every valid serial bit with its cycle number; a
// behavioural receiver rebuilds words from those bits and compares them
// with the words handed to the DUT. A second instance covers LSB-first order.
module tb_bing_to_chuan7;
  import hamming_pkg::*;

  localparam int   W          = CW_WIDTH;
  localparam logic IDLE_LEVEL = 1'b0;

  logic         clk16 = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] cw_in = '0;
  logic         cw_valid = 1'b0;
  logic         cw_ready, ser_out, ser_valid, frame_start, busy;

  logic [W-1:0] cw_in_l = '0;
  logic         cw_valid_l = 1'b0;
  logic         cw_ready_l, ser_out_l, ser_valid_l, frame_start_l, busy_l;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int   cyc;
    logic b;
    logic fs;
  } rx_t;
  rx_t rx_q[$];

  bing_to_chuan7 #(.MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk16(clk16), .rst_n(rst_n), .cw_in(cw_in), .cw_valid(cw_valid),
    .cw_ready(cw_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .busy(busy)
  );

  bing_to_chuan7 #(.MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE_LEVEL)) dut_lsb (
    .clk16(clk16), .rst_n(rst_n), .cw_in(cw_in_l), .cw_valid(cw_valid_l),
    .cw_ready(cw_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .frame_start(frame_start_l), .busy(busy_l)
  );

  always #5 clk16 = ~clk16;

  always @(posedge clk16) cyc <= cyc + 1;

  always @(negedge clk16) begin
    if (ser_valid === 1'b1) rx_q.push_back('{cyc, ser_out, frame_start});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk16);
    #1;
  endtask

  function automatic logic bit_of(input logic [W-1:0] w, input int k, input bit msb);
    return msb ? w[W-1-k] : w[k];
  endfunction

  // Offer one word and hold it until accepted; returns the accepting edge.
  task automatic send_one(input logic [W-1:0] w, output int acc_cyc, output int waited);
    cw_in    = w;
    cw_valid = 1'b1;
    waited   = 0;
    acc_cyc  = -1;
    while (acc_cyc < 0 && waited < 50) begin
      if (cw_ready === 1'b1) begin
        tick();
        acc_cyc = cyc;
      end else begin
        tick();
        waited++;
      end
    end
    cw_valid = 1'b0;
    check("accepted", 32'(acc_cyc >= 0), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    tick();
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  // Behavioural receiver: rebuild MSB-first frames and compare with sent words.
  task automatic check_stream(input string tag, input logic [W-1:0] sent[$],
                              input int first_acc, input bit gapless);
    logic [W-1:0] got;
    int           fs_cnt;
    check({tag, "_nbits"}, 32'(rx_q.size()), 32'(sent.size() * W));
    for (int f = 0; f < sent.size() && (f + 1) * W <= rx_q.size(); f++) begin
      got    = '0;
      fs_cnt = 0;
      for (int k = 0; k < W; k++) begin
        got = {got[W-2:0], rx_q[f*W+k].b};
        if (rx_q[f*W+k].fs === 1'b1) fs_cnt++;
      end
      check({tag, "_word"}, 32'(got), 32'(sent[f]));
      check({tag, "_fs_first"}, 32'(rx_q[f*W].fs), 32'd1);
      check({tag, "_fs_count"}, 32'(fs_cnt), 32'd1);
      // Bits of a single frame always occupy consecutive cycles.
      check({tag, "_frame_contig"}, 32'(rx_q[f*W+W-1].cyc - rx_q[f*W].cyc), 32'(W - 1));
    end
    if (rx_q.size() > 0) begin
      check({tag, "_latency"}, 32'(rx_q[0].cyc), 32'(first_acc + 1));
      if (gapless)
        check({tag, "_gapless"}, 32'(rx_q[rx_q.size()-1].cyc - rx_q[0].cyc),
              32'(rx_q.size() - 1));
    end
  endtask

  initial begin
    logic [W-1:0] words[$];
    int           acc0, acc, waited;
    logic [W-1:0] w;

    // ---- Reset state -------------------------------------------------------
    tick();
    tick();
    check("rst_ser_out", 32'(ser_out), 32'(IDLE_LEVEL));
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(cw_ready), 32'd1);

    // ---- Single word while idle --------------------------------------------
    rx_q.delete();
    words = '{7'b1011001};
    send_one(7'b1011001, acc0, waited);
    check("single_wait", 32'(waited), 32'd0);
    drain();
    check_stream("single", words, acc0, 1'b1);
    check("single_idle_out", 32'(ser_out), 32'(IDLE_LEVEL));
    check("single_idle_valid", 32'(ser_valid), 32'd0);

    // ---- Back-to-back with cw_valid held -----------------------------------
    rx_q.delete();
    words = '{7'h55, 7'h2A, 7'h7F};
    send_one(7'h55, acc0, waited);
    check("b2b_wait0", 32'(waited), 32'd0);
    send_one(7'h2A, acc, waited);
    check("b2b_wait1", 32'(waited), 32'd0);
    send_one(7'h7F, acc, waited);
    // Held word waits until frame 0 is on its last bit.
    check("b2b_wait2", 32'(waited), 32'(W - 1));
    check("b2b_acc2", 32'(acc - acc0), 32'(W + 1));
    drain();
    check_stream("b2b", words, acc0, 1'b1);

    // ---- Backpressure; cw_in changes without valid are ignored -------------
    rx_q.delete();
    words = '{7'h40, 7'h33, 7'h12};
    send_one(7'h40, acc0, waited);
    send_one(7'h33, acc, waited);
    cw_in = 7'h7F;
    tick();
    cw_in = 7'h00;
    tick();
    check("bp_ready_low", 32'(cw_ready), 32'd0);
    send_one(7'h12, acc, waited);
    check("bp_wait", 32'(waited), 32'(W - 3));
    check("bp_acc", 32'(acc - acc0), 32'(W + 1));
    drain();
    check_stream("bp", words, acc0, 1'b1);

    // ---- LSB-first instance ------------------------------------------------
    w          = 7'b0000011;
    cw_in_l    = w;
    cw_valid_l = 1'b1;
    check("lsb_ready", 32'(cw_ready_l), 32'd1);
    tick();
    cw_valid_l = 1'b0;
    for (int k = 0; k < W; k++) begin
      tick();
      check("lsb_bit", 32'(ser_out_l), 32'(bit_of(w, k, 1'b0)));
      check("lsb_valid", 32'(ser_valid_l), 32'd1);
      check("lsb_fs", 32'(frame_start_l), 32'(k == 0));
    end
    tick();
    check("lsb_end_valid", 32'(ser_valid_l), 32'd0);
    check("lsb_end_busy", 32'(busy_l), 32'd0);

    // ---- Reset mid-frame with a word held ----------------------------------
    send_one(7'h6B, acc, waited);
    send_one(7'h15, acc, waited);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ser_out", 32'(ser_out), 32'(IDLE_LEVEL));
    check("midrst_ser_valid", 32'(ser_valid), 32'd0);
    check("midrst_frame_start", 32'(frame_start), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rx_q.delete();
    for (int i = 0; i < 12; i++) tick();
    check("midrst_no_bits", 32'(rx_q.size()), 32'd0);
    check("midrst_ready", 32'(cw_ready), 32'd1);

    // ---- 100 random words streamed continuously ----------------------------
    rx_q.delete();
    words.delete();
    for (int i = 0; i < 100; i++) begin
      w = W'($urandom);
      words.push_back(w);
      send_one(w, acc, waited);
      if (i == 0) acc0 = acc;
    end
    drain();
    check_stream("stream", words, acc0, 1'b1);

    // ---- Random words with random idle gaps (underrun path) ----------------
    rx_q.delete();
    words.delete();
    for (int i = 0; i < 30; i++) begin
      w = W'($urandom);
      words.push_back(w);
      send_one(w, acc, waited);
      if (i == 0) acc0 = acc;
      repeat ($urandom_range(0, 9)) tick();
    end
    drain();
    check_stream("gaps", words, acc0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
